// File: rtl/drop_ctrl.sv
// Falling-object controller: spawns an object, steps its row once per frame tick,
// stops it on the floor or on a collision, holds it for a number of frames, then idles.
module drop_ctrl #(
  parameter int Y_W         = 10,
  parameter int Y_START     = 0,
  parameter int Y_FLOOR     = 479,
  parameter int HOLD_FRAMES = 30
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           frame_tick,
  input  logic           spawn_req,
  input  logic [Y_W-1:0] spawn_x,
  input  logic [5:0]     speed,
  input  logic           hit,
  output logic           spawn_ack,
  output logic           busy,
  output logic [Y_W-1:0] obj_x,
  output logic [Y_W-1:0] obj_y,
  output logic           landed,
  output logic [7:0]     land_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FALL = 2'd1,
    S_LAND = 2'd2
  } state_t;

  localparam logic [Y_W-1:0] START     = Y_W'(Y_START);
  localparam logic [Y_W-1:0] FLOOR     = Y_W'(Y_FLOOR);
  localparam logic [5:0]     HOLD_LAST = 6'(HOLD_FRAMES - 1);

  state_t         state;
  state_t         state_nx;
  logic [5:0]     speed_l;
  logic [5:0]     hold_cnt;
  logic [Y_W:0]   y_sum;
  logic           floor_reach;
  logic           hold_done;

  logic           accept;
  logic           enter_land;
  logic           step;
  logic           ack_nx;
  logic           landed_nx;
  logic           busy_nx;

  // One guard bit on the sum keeps a large speed near the floor from wrapping.
  function automatic logic [Y_W-1:0] clamp_floor(input logic [Y_W:0] sum);
    if (sum >= {1'b0, FLOOR})
      return FLOOR;
    else
      return sum[Y_W-1:0];
  endfunction

  function automatic logic [5:0] min_one(input logic [5:0] s);
    return (s == 6'd0) ? 6'd1 : s;
  endfunction

  assign y_sum       = {1'b0, obj_y} + {{(Y_W-5){1'b0}}, speed_l};
  assign floor_reach = (y_sum >= {1'b0, FLOOR});
  assign hold_done   = frame_tick && (hold_cnt == HOLD_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (spawn_req) state_nx = S_FALL;
      S_FALL: if (hit || (frame_tick && floor_reach)) state_nx = S_LAND;
      S_LAND: if (hold_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // hit outranks frame_tick, so a simultaneous tick never moves the object.
  always_comb begin
    accept     = (state == S_IDLE) && spawn_req;
    enter_land = (state == S_FALL) && (state_nx == S_LAND);
    step       = (state == S_FALL) && !hit && frame_tick;
    ack_nx     = accept;
    landed_nx  = enter_land;
    busy_nx    = (state_nx != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spawn_ack  <= 1'b0;
      landed     <= 1'b0;
      busy       <= 1'b0;
      land_count <= 8'd0;
    end else begin
      spawn_ack <= ack_nx;
      landed    <= landed_nx;
      busy      <= busy_nx;
      if (enter_land)
        land_count <= land_count + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      obj_x    <= '0;
      obj_y    <= START;
      speed_l  <= 6'd1;
      hold_cnt <= 6'd0;
    end else begin
      if (accept) begin
        obj_x    <= spawn_x;
        obj_y    <= START;
        speed_l  <= min_one(speed);
        hold_cnt <= 6'd0;
      end else if (step) begin
        obj_y <= clamp_floor(y_sum);
      end
      if ((state == S_LAND) && frame_tick)
        hold_cnt <= hold_cnt + 6'd1;
    end
  end

endmodule

// File: tb/tb_drop_ctrl.sv
// Randomized scoreboard bench for drop_ctrl: a behavioural model queues the expected
// per-cycle outputs, and a monitor on the falling edge pops and compares them.
module tb_drop_ctrl;

  localparam int Y_W         = 10;
  localparam int Y_START     = 0;
  localparam int Y_FLOOR     = 479;
  localparam int HOLD_FRAMES = 30;

  logic           Clk = 1'b0;
  logic           Reset_n = 1'b0;
  logic           frame_tick = 1'b0;
  logic           spawn_req = 1'b0;
  logic [Y_W-1:0] spawn_x = '0;
  logic [5:0]     speed = 6'd0;
  logic           hit = 1'b0;
  logic           spawn_ack;
  logic           busy;
  logic [Y_W-1:0] obj_x;
  logic [Y_W-1:0] obj_y;
  logic           landed;
  logic [7:0]     land_count;

  drop_ctrl #(
    .Y_W(Y_W), .Y_START(Y_START), .Y_FLOOR(Y_FLOOR), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .spawn_req(spawn_req),
    .spawn_x(spawn_x), .speed(speed), .hit(hit), .spawn_ack(spawn_ack), .busy(busy),
    .obj_x(obj_x), .obj_y(obj_y), .landed(landed), .land_count(land_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    bit busy;
    bit ack;
    bit landed;
    int cnt;
  } snap_t;

  snap_t sbq[$];
  snap_t exp_s;
  snap_t new_s;

  int checks = 0;
  int failures = 0;
  int n_landed = 0;

  // Reference model: phase 0 idle, 1 falling, 2 resting on the ground.
  int m_ph = 0, m_x = 0, m_y = Y_START, m_spd = 1, m_ticks = 0, m_cnt = 0, m_total = 0;
  bit m_ack, m_land;

  always @(posedge Clk) begin
    if (Reset_n) begin
      m_ack = 0;
      m_land = 0;
      if (m_ph == 0) begin
        if (spawn_req) begin
          m_x = int'(spawn_x);
          m_spd = (speed == 6'd0) ? 1 : int'(speed);
          m_y = Y_START;
          m_ph = 1;
          m_ack = 1;
        end
      end else if (m_ph == 1) begin
        if (hit) begin
          m_land = 1;
        end else if (frame_tick) begin
          if (m_y + m_spd >= Y_FLOOR) begin
            m_y = Y_FLOOR;
            m_land = 1;
          end else begin
            m_y = m_y + m_spd;
          end
        end
        if (m_land) begin
          m_ph = 2;
          m_ticks = 0;
          m_cnt = (m_cnt + 1) % 256;
          m_total++;
        end
      end else begin
        if (frame_tick) begin
          m_ticks++;
          if (m_ticks == HOLD_FRAMES) m_ph = 0;
        end
      end
      new_s.x = m_x;
      new_s.y = m_y;
      new_s.busy = (m_ph != 0);
      new_s.ack = m_ack;
      new_s.landed = m_land;
      new_s.cnt = m_cnt;
      sbq.push_back(new_s);
    end
  end

  always @(negedge Clk) begin
    if (Reset_n && sbq.size() > 0) begin
      exp_s = sbq.pop_front();
      checks++;
      if (obj_x !== 10'(exp_s.x) || obj_y !== 10'(exp_s.y) || busy !== exp_s.busy ||
          spawn_ack !== exp_s.ack || landed !== exp_s.landed || land_count !== 8'(exp_s.cnt)) begin
        failures++;
        $display("FAIL cycle_state t=%0t got x=%0d y=%0d busy=%0b ack=%0b landed=%0b cnt=%0d want x=%0d y=%0d busy=%0b ack=%0b landed=%0b cnt=%0d",
                 $time, obj_x, obj_y, busy, spawn_ack, landed, land_count,
                 exp_s.x, exp_s.y, exp_s.busy, exp_s.ack, exp_s.landed, exp_s.cnt);
      end
    end
    if (Reset_n && landed === 1'b1) n_landed++;
  end

  int tick_per = 4;
  int tick_ctr = 0;

  task automatic step();
    @(posedge Clk);
    #1;
    tick_ctr++;
    frame_tick = (tick_per > 0) && (tick_ctr % tick_per == 0);
  endtask

  task automatic spawn(input int x, input int s);
    spawn_x = 10'(x);
    speed = 6'(s);
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    spawn_x = 10'($urandom);
    speed = 6'($urandom);
  endtask

  task automatic timeout_check(input bit ok, input string name);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout: got phase=%0d y=%0d want condition reached", name, m_ph, m_y);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_ph != 0 && n < budget) begin
      step();
      n++;
    end
    timeout_check(m_ph == 0, "wait_idle");
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    sbq.delete();
    m_ph = 0; m_x = 0; m_y = Y_START; m_spd = 1; m_ticks = 0; m_cnt = 0;
    spawn_req = 1'b0;
    hit = 1'b0;
    #1;
    checks++;
    if (obj_x !== 10'd0 || obj_y !== 10'(Y_START) || busy !== 1'b0 || spawn_ack !== 1'b0 ||
        landed !== 1'b0 || land_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_now got x=%0d y=%0d busy=%0b ack=%0b landed=%0b cnt=%0d want all zero",
               obj_x, obj_y, busy, spawn_ack, landed, land_count);
    end
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int base;

    do_reset();
    repeat (3) step();

    // Basic drop: column 200, 8 rows per tick, a tick every 4 cycles.
    tick_per = 4;
    spawn(200, 8);
    wait_idle(4000);

    // Speed zero steps one row per tick; speed 63 clamps at the floor.
    tick_per = 2;
    spawn($urandom_range(0, 1023), 0);
    wait_idle(3000);
    spawn($urandom_range(0, 1023), 63);
    wait_idle(1000);

    // Collision away from a tick at row 64.
    tick_per = 4;
    spawn(77, 8);
    n = 0;
    do begin step(); n++; end while (!(m_ph == 1 && m_y == 64 && !frame_tick) && n < 500);
    timeout_check(m_y == 64, "reach_64");
    hit = 1'b1;
    step();
    hit = 1'b0;
    wait_idle(1000);

    // Collision on the same cycle as a tick at row 80.
    spawn(33, 8);
    n = 0;
    do begin step(); n++; end while (!(m_ph == 1 && m_y == 80 && frame_tick) && n < 500);
    timeout_check(m_y == 80, "reach_80");
    hit = 1'b1;
    step();
    hit = 1'b0;
    wait_idle(1000);

    // Requests while busy are ignored.
    tick_per = 3;
    spawn(123, 20);
    n = 0;
    while (m_ph != 0 && n < 3000) begin
      step();
      spawn_req = ($urandom_range(0, 2) == 0);
      spawn_x = 10'($urandom);
      speed = 6'($urandom);
      n++;
    end
    spawn_req = 1'b0;
    timeout_check(m_ph == 0, "busy_reject");
    step();

    // Level held across the return to idle is accepted in the first idle cycle.
    spawn(321, 40);
    spawn_req = 1'b1;
    n = 0;
    while (m_ph != 2 && n < 1000) begin step(); n++; end
    while (m_ph != 1 && n < 2000) begin step(); n++; end
    spawn_req = 1'b0;
    timeout_check(m_ph == 1 && m_y == Y_START, "held_req");
    wait_idle(2000);

    // Reset while falling at row 100.
    spawn(500, 10);
    n = 0;
    while (m_y != 100 && n < 1000) begin step(); n++; end
    timeout_check(m_y == 100, "reach_100");
    do_reset();
    repeat (10) step();

    // Randomized traffic.
    tick_per = 3;
    for (int i = 0; i < 3000; i++) begin
      step();
      spawn_req = ($urandom_range(0, 3) == 0);
      spawn_x = 10'($urandom);
      speed = 6'($urandom);
      hit = ($urandom_range(0, 15) == 0);
    end
    spawn_req = 1'b0;
    hit = 1'b0;
    wait_idle(2000);

    // 256 back-to-back drops wrap the landing counter.
    do_reset();
    tick_per = 2;
    n_landed = 0;
    base = m_total;
    speed = 6'd63;
    spawn_req = 1'b1;
    n = 0;
    while (m_total - base < 256 && n < 30000) begin step(); n++; end
    spawn_req = 1'b0;
    step();
    timeout_check(m_total - base == 256, "wrap_drops");
    checks++;
    if (n_landed != 256 || land_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap got landed_pulses=%0d land_count=%0d want 256 and 0", n_landed, land_count);
    end
    wait_idle(2000);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
